// File: rtl/full_adder_pkg.sv
// Shared types and limits for the registered ripple-carry adder.
package full_adder_pkg;

    localparam int unsigned FA_MAX_WIDTH = 64;

    typedef struct packed {
        logic                    cout;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder cell, the leaf of the ripple chain.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/full_adder.sv
// Registered, valid-qualified ripple-carry adder with one-cycle latency.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] a_qual;
    logic [WIDTH-1:0] b_qual;
    logic             cin_qual;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   carry;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;

    // Gate operands so idle-cycle X on a/b/cin never reaches the chain.
    always_comb begin
        a_qual   = in_valid ? a : '0;
        b_qual   = in_valid ? b : '0;
        cin_qual = in_valid ? cin : 1'b0;
    end

    assign carry[0] = cin_qual;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a_qual[i]),
            .b    (b_qual[i]),
            .cin  (carry[i]),
            .sum  (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum_bits;
            cout_d = carry[WIDTH];
        end
        if (!rst_n) begin
            sum_d   = '0;
            cout_d  = 1'b0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q   <= sum_d;
        cout_q  <= cout_d;
        valid_q <= valid_d;
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

`ifdef FULL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
        end
        if (!rst_n) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8 with directed vectors.
module tb_full_adder;
    import full_adder_pkg::*;

    typedef struct packed {
        fa_result_t r;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, c1, a1, b1;
    logic       ov1, s1, co1;
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic       ov8, co8;
    logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
    logic       of1, of8;
`endif

    exp_t q1[$];
    exp_t q8[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   n1 = 0;
    int   n8 = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .cin       (c1),
        .out_valid (ov1),
        .sum       (s1),
        .cout      (co1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (of1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .cin       (c8),
        .out_valid (ov8),
        .sum       (s8),
        .cout      (co8)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (of8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("w1_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                n1++;
                check("w1_sum", 64'(s1), 64'(e.r.sum[0]));
                check("w1_cout", 64'(co1), 64'(e.r.cout));
`ifdef FULL_ADDER_OVF_EN
                check("w1_ovf", 64'(of1), 64'(e.ovf));
`endif
            end
        end
        if (ov8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                n8++;
                check("w8_sum", 64'(s8), 64'(e.r.sum[7:0]));
                check("w8_cout", 64'(co8), 64'(e.r.cout));
`ifdef FULL_ADDER_OVF_EN
                check("w8_ovf", 64'(of8), 64'(e.ovf));
`endif
            end
        end
    end

    // {a, b, cin, cout, sum, ovf}
    logic [5:0] w1_vec [12] = '{
        6'b111_11_0, 6'b111_11_0, 6'b010_01_0, 6'b110_10_1,
        6'b000_00_0, 6'b001_01_1, 6'b010_01_0, 6'b011_10_0,
        6'b100_01_0, 6'b101_10_0, 6'b110_10_1, 6'b111_11_0
    };

    // {a, b, cin, cout, sum, ovf}
    logic [26:0] w8_vec [4] = '{
        {8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0},
        {8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1},
        {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b1},
        {8'h10, 8'h02, 1'b0, 1'b0, 8'h12, 1'b0}
    };

    initial begin
        exp_t e;
        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;

        // Reset overrides in_valid for two edges.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_w1_valid", 64'(ov1), 64'd0);
            check("rst_w1_sum_cout", 64'({co1, s1}), 64'd0);
            check("rst_w8_valid", 64'(ov8), 64'd0);
            check("rst_w8_sum_cout", 64'({co8, s8}), 64'd0);
        end
        rst_n = 1'b1;
        v8 = 1'b0;

        // WIDTH=1 directed and exhaustive sequence, back-to-back.
        for (int i = 0; i < 12; i++) begin
            {a1, b1, c1} = w1_vec[i][5:3];
            e = '0;
            e.r.cout   = w1_vec[i][2];
            e.r.sum[0] = w1_vec[i][1];
            e.ovf      = w1_vec[i][0];
            q1.push_back(e);
            @(posedge clk);
            #1;
        end
        v1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w1_result_count", 64'(n1), 64'd12);
        check("w1_idle_valid", 64'(ov1), 64'd0);

        // WIDTH=8 boundaries, ending with a 8'h12 result for the idle-hold test.
        v8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {a8, b8, c8} = w8_vec[i][26:10];
            e = '0;
            e.r.cout     = w8_vec[i][9];
            e.r.sum[7:0] = w8_vec[i][8:1];
            e.ovf        = w8_vec[i][0];
            q8.push_back(e);
            @(posedge clk);
            #1;
        end

        // Idle: random operands with in_valid low must not disturb the held result.
        v8 = 1'b0;
        repeat (3) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("idle_valid", 64'(ov8), 64'd0);
            check("idle_sum_hold", 64'(s8), 64'h12);
            check("idle_cout_hold", 64'(co8), 64'd0);
        end
        check("w8_result_count", 64'(n8), 64'd4);

        // Mid-stream reset: the operation presented with reset is discarded.
        #1;
        v8 = 1'b1; a8 = 8'd5; b8 = 8'd3; c8 = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", 64'(ov8), 64'd0);
        check("midrst_sum_cout", 64'({co8, s8}), 64'd0);
        repeat (2) @(negedge clk);
        check("midrst_no_late_result", 64'(n8), 64'd4);
        check("queues_drained", 64'(q1.size() + q8.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry full adder.
- With the default WIDTH=1 it behaves as a classic 1-bit full adder (a + b + cin → cout, sum) whose result is captured in flops.
- Used as the arithmetic leaf in the datapath adder library; wider instances chain 1-bit cells internally.
- One clock domain, one-cycle result latency, valid-qualified.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands on a/b/cin are valid this cycle.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- cin  input  1  carry in to bit 0.
- out_valid  output  1  sum/cout hold a fresh result.
- sum  output  WIDTH  registered sum bits, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry out of MSB.

Behaviour:
- Reset: on a rising clk with rst_n=0, sum<=0, cout<=0, out_valid<=0. Reset overrides in_valid in the same cycle; an operation in flight is discarded.
- Arithmetic: {cout,sum} = a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
- Carry structure: bit i uses s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i, with c_0 = cin and cout = c_WIDTH.
- Latency: operands sampled at edge N with in_valid=1 appear on sum/cout with out_valid=1 after edge N (one cycle). Back-to-back valid inputs give one result per cycle.
- Idle: in_valid=0 at an edge gives out_valid<=0, and sum/cout hold their last values (no update, no X).
- No backpressure: the consumer must accept every out_valid pulse.
- Boundary cases:
  - all-ones + all-ones + cin=1 → sum all-ones, cout=1.
  - zeros + cin=0 → sum 0, cout 0.
  - WIDTH=1 reduces exactly to the textbook truth table.
- X-handling: no X may propagate from in_valid=0 inputs into the registers.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit, registered, reset 0), equal to the signed two's-complement overflow c_WIDTH ^ c_{WIDTH-1}. For WIDTH=1 it is cin ^ cout. It updates and holds under the same rules as sum.
- Undefined: port ovf and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package full_adder_pkg:
  - constant FA_MAX_WIDTH=64.
  - typedef fa_result_t, a struct of cout and sum for the max width, used by scoreboards.
- Sub-module full_adder_bit: purely combinational 1-bit cell (a, b, cin → sum, cout), instantiated WIDTH times in a generate loop.
- The top level owns only the carry chain wiring, the input qualification and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and a=b=cin=1 → sum=0, cout=0, out_valid=0 throughout; release, then a=1, b=1, cin=1 → next cycle sum=1, cout=1, out_valid=1.
- WIDTH=1 vector sequence, one per cycle with in_valid=1:
  - (1,1,1) → cout=1, sum=1.
  - (0,1,0) → cout=0, sum=1.
  - (1,1,0) → cout=1, sum=0.
  - Each result appears exactly one cycle later.
- WIDTH=1 exhaustive: all 8 combinations of a/b/cin back-to-back → every result matches a+b+cin; out_valid stays high for 8 cycles.
- WIDTH=8 boundaries:
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
  - a=8'h80, b=8'h80, cin=0 → sum=8'h00, cout=1 (ovf=1 with FULL_ADDER_OVF_EN).
  - a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0 (ovf=1).
- Idle hold: a result of sum=8'h12, then in_valid=0 for 3 cycles with random a/b → sum stays 8'h12, out_valid=0.
- Mid-stream reset: in_valid=1 with a=5, b=3, then rst_n=0 at the next edge → outputs 0 and out_valid=0; the pending result never appears.
